fc_argmax_classifier: RTL and testbench
=======================================

// Module: fc_argmax_classifier
// PURPOSE
//  Final MNIST classifier stage, downstream of the convolution top block.
//  Takes the flat conv feature vector (OUTPUT_DIM x OUTPUT_DIM words) and applies ReLU.
//  Runs a serial fully-connected layer (N_CLASSES dot products, weights from a 1-cycle-latency ROM).
//  Outputs the argmax class index and its score.
// PARAMETERS
//  OUTPUT_DIM   2    conv output side; N_IN = OUTPUT_DIM*OUTPUT_DIM features
//  OUTBITWIDTH  25   feature word width, two's complement
//  W_WIDTH      8    weight width, two's complement
//  N_CLASSES    10   number of output classes
//  CLASS_BIT    4    width of class index, >= clog2(N_CLASSES)
//  WADDR_W      6    weight ROM address width, 2**WADDR_W >= N_CLASSES*N_IN
//  ACC_W        40   accumulator / score width, two's complement
// PORTS
//  clk          in   1                              rising-edge clock
//  reset        in   1                              synchronous, active-high
//  start        in   1                              level; tie to conv done
//  features     in   OUTPUT_DIM*OUTPUT_DIM*OUTBITWIDTH  conv result vector
//  w_addr       out  WADDR_W                        weight ROM address
//  w_data       in   W_WIDTH                        ROM data, valid 1 cycle after w_addr
//  busy         out  1                              high from LOAD through CMP
//  done         out  1                              result valid, held until start drops
//  class_idx    out  CLASS_BIT                      argmax class
//  max_score    out  ACC_W                          score of class_idx
// BEHAVIOUR
//  Reset (any state, mid-run included):
//   - state=IDLE; busy, done, class_idx, max_score, w_addr = 0.
//   - All internal counters and accumulators are cleared.
//  Feature packing:
//   - Feature n = row*OUTPUT_DIM+col occupies features[TOTAL-1-n*OUTBITWIDTH -: OUTBITWIDTH].
//   - Feature 0 is therefore in the MSBs.
//  Weight layout: weight(c,n) is stored at address c*N_IN+n.
//  FSM:
//   - IDLE -> LOAD when start=1. start=0 keeps the FSM in IDLE.
//   - LOAD (1 cycle): latch all features; negative values become 0 (ReLU). Set c=0, best=most-negative ACC_W value, best_idx=0.
//   - MAC: N_IN+1 cycles per class.
//     - Cycles k=0..N_IN-1 drive w_addr=c*N_IN+k.
//     - Cycles k=1..N_IN perform acc += sext(feat[k-1]) * sext(w_data); the product is full-width signed.
//     - acc is cleared on MAC entry.
//   - CMP (1 cycle): if acc > best (signed), then best=acc and best_idx=c.
//     - Strict > means a tie keeps the lowest class index.
//     - If c==N_CLASSES-1 go to DONE; else c++ and return to MAC.
//   - DONE: class_idx=best_idx, max_score=best, done=1, busy=0.
//     - Hold all outputs while start=1.
//     - start=0 -> IDLE; done drops, class_idx and max_score hold their values.
//  Latency:
//   - Count the edge that samples start=1 in IDLE as edge 0.
//   - done rises after edge 1+N_CLASSES*(N_IN+2)+1. With defaults this is edge 62.
//  start is ignored outside IDLE and DONE. Dropping start mid-run does not abort.
//  Arithmetic:
//   - Accumulation wraps mod 2**ACC_W. The defaults cannot overflow: 33-bit product, 4 terms.
//   - w_addr holds its last value outside MAC.
// TESTING
//  1 Reset mid-MAC (edge 20) -> next cycle: IDLE, busy=0, done=0, class_idx=0, max_score=0.
//  2 features={10,20,30,40}; weight(c,n)=c for all n; start held
//    -> done at edge 62, class_idx=9, max_score=900.
//  3 features={-5,0,7,0}; weight(3,2)=2, all other weights 0
//    -> ReLU zeroes -5; class_idx=3, max_score=14.
//  4 All weights 0 -> all scores 0 (tie); class_idx=0, max_score=0.
//  5 Same as 2, then start 1->0->1 -> done drops for one IDLE cycle, rerun gives identical result at +62 edges.
//  6 weight(c,n)=-1 for every class, features={1,1,1,1}
//    -> negative tie; class_idx=0, max_score=-4 (sign-extended to ACC_W).

Source files
------------

// File: rtl/fc_argmax_classifier_if.sv
// Classifier bus: start/feature input, weight ROM port and argmax result.
// The master side drives start, features and ROM data; the slave is the classifier.
interface fc_argmax_classifier_if #(
    parameter int OUTPUT_DIM  = 2,
    parameter int OUTBITWIDTH = 25,
    parameter int W_WIDTH     = 8,
    parameter int CLASS_BIT   = 4,
    parameter int WADDR_W     = 6,
    parameter int ACC_W       = 40
);
    logic                                          start;
    logic [OUTPUT_DIM*OUTPUT_DIM*OUTBITWIDTH-1:0]  features;
    logic [WADDR_W-1:0]                            w_addr;
    logic signed [W_WIDTH-1:0]                     w_data;
    logic                                          busy;
    logic                                          done;
    logic [CLASS_BIT-1:0]                          class_idx;
    logic signed [ACC_W-1:0]                       max_score;

    modport master (
        output start, features, w_data,
        input  w_addr, busy, done, class_idx, max_score
    );

    modport slave (
        input  start, features, w_data,
        output w_addr, busy, done, class_idx, max_score
    );
endinterface

// File: rtl/fc_argmax_classifier.sv
// Final MNIST stage: ReLU on the conv feature vector, serial fully-connected layer
// against a 1-cycle-latency weight ROM, then argmax over the class scores.
module fc_argmax_classifier #(
    parameter int OUTPUT_DIM  = 2,
    parameter int OUTBITWIDTH = 25,
    parameter int W_WIDTH     = 8,
    parameter int N_CLASSES   = 10,
    parameter int CLASS_BIT   = 4,
    parameter int WADDR_W     = 6,
    parameter int ACC_W       = 40
) (
    input logic                    clk,
    input logic                    reset,
    fc_argmax_classifier_if.slave  bus
);
    localparam int N_IN   = OUTPUT_DIM * OUTPUT_DIM;
    localparam int TOTAL  = N_IN * OUTBITWIDTH;
    localparam int PROD_W = OUTBITWIDTH + W_WIDTH;
    localparam int K_W    = $clog2(N_IN + 1) + 1;
    localparam int FI_W   = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, CMP, DONE} state_t;

    function automatic logic signed [OUTBITWIDTH-1:0] relu(
        input logic signed [OUTBITWIDTH-1:0] x
    );
        return x[OUTBITWIDTH-1] ? '0 : x;
    endfunction

    // Full-width signed product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic signed [OUTBITWIDTH-1:0] f,
        input logic signed [W_WIDTH-1:0]     w
    );
        logic signed [PROD_W-1:0] p;
        p = f * w;
        return ACC_W'(p);
    endfunction

    state_t                         state;
    logic signed [OUTBITWIDTH-1:0]  feat [N_IN];
    logic [K_W-1:0]                 k_p0;
    logic [FI_W-1:0]                fi_p1;
    logic                           vld_p1;
    logic [CLASS_BIT-1:0]           c;
    logic signed [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0]        best;
    logic [CLASS_BIT-1:0]           best_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            for (int i = 0; i < N_IN; i++) feat[i] <= '0;
            k_p0          <= '0;
            fi_p1         <= '0;
            vld_p1        <= 1'b0;
            c             <= '0;
            acc           <= '0;
            best          <= '0;
            best_idx      <= '0;
            bus.w_addr    <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.class_idx <= '0;
            bus.max_score <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state    <= LOAD;
                        bus.busy <= 1'b1;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < N_IN; i++)
                        feat[i] <= relu(bus.features[TOTAL-1-i*OUTBITWIDTH -: OUTBITWIDTH]);
                    c          <= '0;
                    best       <= {1'b1, {(ACC_W-1){1'b0}}};
                    best_idx   <= '0;
                    acc        <= '0;
                    k_p0       <= '0;
                    vld_p1     <= 1'b0;
                    bus.w_addr <= '0;
                    state      <= MAC;
                end
                // p0: address issue for feature k; p1: ROM word for feature k-1 arrives
                MAC: begin
                    if (k_p0 < K_W'(N_IN - 1))
                        bus.w_addr <= bus.w_addr + WADDR_W'(1);
                    if (k_p0 < K_W'(N_IN)) begin
                        vld_p1 <= 1'b1;
                        fi_p1  <= FI_W'(k_p0);
                        k_p0   <= k_p0 + K_W'(1);
                    end else begin
                        vld_p1 <= 1'b0;
                        state  <= CMP;
                    end
                    if (vld_p1)
                        acc <= acc + mac_term(feat[fi_p1], bus.w_data);
                end
                // Strict compare keeps the lowest index on ties.
                CMP: begin
                    if (acc > best) begin
                        best     <= acc;
                        best_idx <= c;
                    end
                    acc    <= '0;
                    k_p0   <= '0;
                    vld_p1 <= 1'b0;
                    if (c == CLASS_BIT'(N_CLASSES - 1)) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end else begin
                        c          <= c + CLASS_BIT'(1);
                        bus.w_addr <= bus.w_addr + WADDR_W'(1);
                        state      <= MAC;
                    end
                end
                DONE: begin
                    bus.class_idx <= best_idx;
                    bus.max_score <= best;
                    bus.done      <= bus.start;
                    if (!bus.start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed bench for fc_argmax_classifier with a synchronous weight ROM model.
module tb_fc_argmax_classifier;
    localparam int OUTPUT_DIM  = 2;
    localparam int OUTBITWIDTH = 25;
    localparam int W_WIDTH     = 8;
    localparam int N_CLASSES   = 10;
    localparam int CLASS_BIT   = 4;
    localparam int WADDR_W     = 6;
    localparam int ACC_W       = 40;
    localparam int N_IN        = OUTPUT_DIM * OUTPUT_DIM;
    localparam int LATENCY     = 62;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic signed [W_WIDTH-1:0] rom [0:(1<<WADDR_W)-1];

    fc_argmax_classifier_if #(
        .OUTPUT_DIM(OUTPUT_DIM), .OUTBITWIDTH(OUTBITWIDTH), .W_WIDTH(W_WIDTH),
        .CLASS_BIT(CLASS_BIT), .WADDR_W(WADDR_W), .ACC_W(ACC_W)
    ) bus ();

    fc_argmax_classifier #(
        .OUTPUT_DIM(OUTPUT_DIM), .OUTBITWIDTH(OUTBITWIDTH), .W_WIDTH(W_WIDTH),
        .N_CLASSES(N_CLASSES), .CLASS_BIT(CLASS_BIT), .WADDR_W(WADDR_W), .ACC_W(ACC_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.w_data <= rom[bus.w_addr];

    function automatic logic [N_IN*OUTBITWIDTH-1:0] pack(input int f0, f1, f2, f3);
        return {OUTBITWIDTH'(f0), OUTBITWIDTH'(f1), OUTBITWIDTH'(f2), OUTBITWIDTH'(f3)};
    endfunction

    task automatic fill_rom(input int mode);
        // mode 0: weight=c; 1: only weight(3,2)=2; 2: all zero; 3: all -1
        for (int a = 0; a < (1 << WADDR_W); a++) rom[a] = '0;
        for (int cl = 0; cl < N_CLASSES; cl++)
            for (int n = 0; n < N_IN; n++)
                case (mode)
                    0: rom[cl*N_IN+n] = W_WIDTH'(cl);
                    1: rom[cl*N_IN+n] = (cl == 3 && n == 2) ? W_WIDTH'(2) : '0;
                    3: rom[cl*N_IN+n] = -8'sd1;
                    default: rom[cl*N_IN+n] = '0;
                endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Raise start, count edges after edge 0 until done (bounded).
    task automatic launch(output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.class_idx !== '0) begin errors++; $display("FAIL reset_class got=%0d want=0", bus.class_idx); end
        checks++; if (bus.max_score !== '0) begin errors++; $display("FAIL reset_score got=%0d want=0", bus.max_score); end
        checks++; if (bus.w_addr !== '0) begin errors++; $display("FAIL reset_waddr got=%0d want=0", bus.w_addr); end
    endtask

    task automatic test_ramp();
        bit to;
        fill_rom(0);
        bus.features = pack(10, 20, 30, 40);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        to = 1'b1;
        for (int e = 1; e <= LATENCY; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ramp_busy_e1 got=%b want=1", bus.busy); end
            end
            if (e == LATENCY - 1) begin
                checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ramp_done_early got=%b want=0", bus.done); end
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_end got=%b want=0", bus.busy); end
            end
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ramp_done_e62 got=%b want=1", bus.done); end
        checks++; if (bus.class_idx !== 4'd9) begin errors++; $display("FAIL ramp_class got=%0d want=9", bus.class_idx); end
        checks++; if (bus.max_score !== 40'sd900) begin errors++; $display("FAIL ramp_score got=%0d want=900", bus.max_score); end
        // Hold while start stays high.
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b1 || bus.class_idx !== 4'd9 || bus.max_score !== 40'sd900)
            begin errors++; $display("FAIL ramp_hold got=%b/%0d/%0d want=1/9/900", bus.done, bus.class_idx, bus.max_score); end
        if (to) begin end
    endtask

    task automatic test_restart();
        int lat;
        // Result of test_ramp still held with start high.
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL restart_done_drop got=%b want=0", bus.done); end
        checks++; if (bus.class_idx !== 4'd9 || bus.max_score !== 40'sd900)
            begin errors++; $display("FAIL restart_hold got=%0d/%0d want=9/900", bus.class_idx, bus.max_score); end
        launch(lat);
        checks++; if (lat !== LATENCY) begin errors++; $display("FAIL restart_latency got=%0d want=%0d", lat, LATENCY); end
        checks++; if (bus.class_idx !== 4'd9 || bus.max_score !== 40'sd900)
            begin errors++; $display("FAIL restart_result got=%0d/%0d want=9/900", bus.class_idx, bus.max_score); end
    endtask

    task automatic test_reset_mid_mac();
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL midrst_ctrl got=%b/%b want=0/0", bus.busy, bus.done); end
        checks++; if (bus.class_idx !== '0 || bus.max_score !== '0 || bus.w_addr !== '0)
            begin errors++; $display("FAIL midrst_out got=%0d/%0d/%0d want=0/0/0", bus.class_idx, bus.max_score, bus.w_addr); end
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b want=0", bus.busy); end
        launch(lat);
        checks++; if (lat !== LATENCY || bus.class_idx !== 4'd9 || bus.max_score !== 40'sd900)
            begin errors++; $display("FAIL midrst_rerun got=%0d/%0d/%0d want=62/9/900", lat, bus.class_idx, bus.max_score); end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_single_weight();
        int lat;
        fill_rom(1);
        bus.features = pack(-5, 0, 7, 0);
        launch(lat);
        checks++; if (lat !== LATENCY || bus.class_idx !== 4'd3 || bus.max_score !== 40'sd14)
            begin errors++; $display("FAIL single_w got=%0d/%0d/%0d want=62/3/14", lat, bus.class_idx, bus.max_score); end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_relu_neg();
        int lat;
        // Without ReLU every class would score +5.
        fill_rom(3);
        bus.features = pack(-5, 0, 0, 0);
        launch(lat);
        checks++; if (bus.class_idx !== 4'd0 || bus.max_score !== 40'sd0)
            begin errors++; $display("FAIL relu_neg got=%0d/%0d want=0/0", bus.class_idx, bus.max_score); end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_zero_tie();
        int lat;
        fill_rom(2);
        bus.features = pack(10, 20, 30, 40);
        launch(lat);
        checks++; if (bus.done !== 1'b1 || bus.class_idx !== 4'd0 || bus.max_score !== 40'sd0)
            begin errors++; $display("FAIL zero_tie got=%b/%0d/%0d want=1/0/0", bus.done, bus.class_idx, bus.max_score); end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_negative_tie();
        int lat;
        fill_rom(3);
        bus.features = pack(1, 1, 1, 1);
        launch(lat);
        checks++; if (bus.class_idx !== 4'd0 || bus.max_score !== -40'sd4)
            begin errors++; $display("FAIL neg_tie got=%0d/%h want=0/fffffffffc", bus.class_idx, bus.max_score); end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.features = '0;
        fill_rom(2);
        test_reset();
        test_ramp();
        test_restart();
        test_reset_mid_mac();
        test_single_weight();
        test_relu_neg();
        test_zero_tie();
        test_negative_tie();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
